register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Next-generation processor register file: one write port, READ_PORTS async read ports,
//  optional hardwired-zero R0 and optional write-to-read bypass. Contents are zeroed by a
//  hardware clear sequencer after reset or on request; busy_o stalls the control matrix.
//  Sits between the control matrix/ALU writeback and the ALU source muxes.
// PARAMETERS
//  DATA_WIDTH   16  bits per register
//  SELECT_SIZE  3   select width; WORDS = 1<<SELECT_SIZE registers
//  READ_PORTS   2   number of independent read ports (>=1)
//  ZERO_REG     0   1: R0 always reads 0, writes to R0 discarded
//  BYPASS       1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clk_i       in   1                          clock, all state on rising edge
//  rst_i       in   1                          async reset, active high
//  reg_we_i    in   1                          write enable, active LOW
//  reg_dst_i   in   SELECT_SIZE                write register select
//  data_i      in   DATA_WIDTH                 write data
//  reg_src_i   in   READ_PORTS*SELECT_SIZE     read selects, port p at [p*SELECT_SIZE +: SELECT_SIZE]
//  src_o       out  READ_PORTS*DATA_WIDTH      read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//  clear_i     in   1                          sync pulse: start clear sweep
//  busy_o      out  1                          1 while clear sweep in progress
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-high.
//  - Storage is a RAM-style array, not reset. Async reset forces the FSM only:
//    state=CLEAR, clr_idx=0, busy_o=1. While rst_i is high, src_o=0.
//  - FSM states:
//    - IDLE: busy_o=0. clear_i=1 -> CLEAR, clr_idx=0.
//    - CLEAR: busy_o=1. Each rising edge writes 0 to bank[clr_idx] and increments clr_idx.
//      On the edge writing WORDS-1 -> IDLE. clr_idx never wraps past WORDS-1.
//  - Timing: busy_o is high for exactly WORDS rising edges after rst_i deasserts, or after
//    the edge sampling clear_i.
//  - clear_i in CLEAR is ignored; the sweep does not restart.
//  - rst_i mid-sweep restarts the sweep at clr_idx=0.
//  - While busy_o=1:
//    - reg_we_i is ignored; the write is dropped, not queued.
//    - All src_o lanes are forced to 0.
//  - Write (IDLE, reg_we_i=0): bank[reg_dst_i] <= data_i on the rising edge.
//    If ZERO_REG=1 and reg_dst_i=0, no write occurs.
//  - Read: combinational, zero-cycle latency; lane p = bank[sel_p].
//    - ZERO_REG=1 and sel_p=0 -> lane p reads 0. This takes precedence over bypass.
//    - BYPASS=1, IDLE, reg_we_i=0 and sel_p==reg_dst_i -> lane p = data_i (write-first).
//      BYPASS=0 -> lane p returns the old value until after the edge.
//  - Multiple lanes may select the same register; each lane resolves independently.
//  - Widths: the counter is SELECT_SIZE+1 bits internally so the terminal compare is exact.
//    No arithmetic on data.
// TESTING (DATA_WIDTH=16, SELECT_SIZE=3, READ_PORTS=3 unless noted)
//  - Reset release: count busy_o edges -> busy_o=1 for 8 edges. Then all 8 regs read 0000.
//    Writes during busy are lost.
//  - Write R5=BEEF, then read R5 on lanes 0 and 2 -> both BEEF next cycle.
//    With BYPASS=1, R3=1234 written while lane 1 selects R3 -> lane 1 reads 1234
//    in the same cycle. Repeat with BYPASS=0 -> old value until the edge.
//  - ZERO_REG=1: write R0=FFFF with bypass active -> R0 reads 0000 in the write cycle
//    and after it.
//  - Fill R0..R7 with A0n0, pulse clear_i -> busy_o for 8 edges, all regs 0000.
//    A second clear_i pulse at sweep cycle 3 does not extend busy_o.
//  - Assert rst_i asynchronously (between edges) at sweep cycle 4 -> busy_o stays 1,
//    and a full 8-edge sweep follows release.

Source files
------------

// File: rtl/register_file_mp.sv
// Register file: one write port, READ_PORTS combinational read ports, optional hardwired R0 and write bypass.
// Latency: reads zero-cycle, writes land on the rising edge. Backpressure: busy_o high during the clear sweep, writes dropped.
// Storage is not reset; a one-word-per-cycle sweep zeroes it after reset or a clear_i pulse.
module register_file_mp #(
    parameter int DATA_WIDTH  = 16,
    parameter int SELECT_SIZE = 3,
    parameter int READ_PORTS  = 2,
    parameter bit ZERO_REG    = 1'b0,
    parameter bit BYPASS      = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              reg_we_i,
    input  logic [SELECT_SIZE-1:0]            reg_dst_i,
    input  logic [DATA_WIDTH-1:0]             data_i,
    input  logic [READ_PORTS*SELECT_SIZE-1:0] reg_src_i,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  src_o,
    input  logic                              clear_i,
    output logic                              busy_o
);

    localparam int WORDS = 1 << SELECT_SIZE;
    localparam int CW    = SELECT_SIZE + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    logic [CW-1:0]           clr_idx;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   bank [WORDS];
    logic                    wr_en;

    // R0 writes are discarded when it is hardwired; any write is dropped mid-sweep.
    assign wr_en = !busy_q && !reg_we_i && !(ZERO_REG && (reg_dst_i == '0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_i) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clear_i is ignored here: a running sweep never restarts.
                    if (clr_idx == LAST_IDX) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + CW'(1);
                    end
                end
                default: begin
                    state  <= CLEAR;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == CLEAR) begin
            bank[clr_idx[SELECT_SIZE-1:0]] <= '0;
        end else if (wr_en) begin
            bank[reg_dst_i] <= data_i;
        end
    end

    assign busy_o = busy_q;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_lane
        logic [SELECT_SIZE-1:0] sel;
        logic [DATA_WIDTH-1:0]  lane;

        assign sel = reg_src_i[p*SELECT_SIZE +: SELECT_SIZE];

        // Priority: reset/sweep blanking, then hardwired R0, then write-first bypass.
        always_comb begin
            lane = bank[sel];
            if (rst_i || busy_q) begin
                lane = '0;
            end else if (ZERO_REG && (sel == '0)) begin
                lane = '0;
            end else if (BYPASS && !reg_we_i && (sel == reg_dst_i)) begin
                lane = data_i;
            end
        end

        assign src_o[p*DATA_WIDTH +: DATA_WIDTH] = lane;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: three instances (bypass, no bypass, hardwired R0) share stimulus
// and are compared against an array-based reference model.
module tb_register_file_mp;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        reg_we_i = 1'b1;
    logic [2:0]  reg_dst_i = '0;
    logic [15:0] data_i = '0;
    logic [8:0]  reg_src_i = '0;
    logic        clear_i = 1'b0;
    logic [47:0] src_all [3];
    logic        busy_all [3];

    int checks = 0;
    int errors = 0;

    // Reference model: register contents per instance plus remaining sweep edges.
    logic [15:0] m_bank [3][8];
    int          sweep_left = 8;

    always #5 clk_i = ~clk_i;

    register_file_mp #(.DATA_WIDTH(16), .SELECT_SIZE(3), .READ_PORTS(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_byp (
        .clk_i(clk_i), .rst_i(rst_i), .reg_we_i(reg_we_i), .reg_dst_i(reg_dst_i), .data_i(data_i),
        .reg_src_i(reg_src_i), .src_o(src_all[0]), .clear_i(clear_i), .busy_o(busy_all[0]));

    register_file_mp #(.DATA_WIDTH(16), .SELECT_SIZE(3), .READ_PORTS(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nobyp (
        .clk_i(clk_i), .rst_i(rst_i), .reg_we_i(reg_we_i), .reg_dst_i(reg_dst_i), .data_i(data_i),
        .reg_src_i(reg_src_i), .src_o(src_all[1]), .clear_i(clear_i), .busy_o(busy_all[1]));

    register_file_mp #(.DATA_WIDTH(16), .SELECT_SIZE(3), .READ_PORTS(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_zero (
        .clk_i(clk_i), .rst_i(rst_i), .reg_we_i(reg_we_i), .reg_dst_i(reg_dst_i), .data_i(data_i),
        .reg_src_i(reg_src_i), .src_o(src_all[2]), .clear_i(clear_i), .busy_o(busy_all[2]));

    function automatic bit zcfg(int i);
        return i == 2;
    endfunction

    function automatic bit bcfg(int i);
        return i != 1;
    endfunction

    function automatic logic exp_busy();
        return rst_i || (sweep_left > 0);
    endfunction

    function automatic logic [15:0] exp_lane(int i, int p);
        logic [2:0] sel;
        sel = reg_src_i[p*3 +: 3];
        if (exp_busy()) return 16'h0000;
        if (zcfg(i) && sel == 3'd0) return 16'h0000;
        if (bcfg(i) && !reg_we_i && sel == reg_dst_i) return data_i;
        return m_bank[i][sel];
    endfunction

    function automatic void zero_model();
        for (int i = 0; i < 3; i++)
            for (int r = 0; r < 8; r++)
                m_bank[i][r] = 16'h0000;
    endfunction

    // Called right after a rising edge with the inputs that edge sampled.
    function automatic void model_edge();
        if (rst_i) begin
            sweep_left = 8;
            zero_model();
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else begin
            if (!reg_we_i)
                for (int i = 0; i < 3; i++)
                    if (!(zcfg(i) && reg_dst_i == 3'd0)) m_bank[i][reg_dst_i] = data_i;
            if (clear_i) begin
                sweep_left = 8;
                zero_model();
            end
        end
    endfunction

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        step();
        step();
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy_all[i] !== 1'b1 || src_all[i] !== 48'h0) begin
                errors++;
                $display("FAIL reset_hold inst%0d: busy=%b src=%h, required busy=1 src=0", i, busy_all[i], src_all[i]);
            end
        end
        rst_i = 1'b0;
        cnt = 0;
        while (busy_all[0] === 1'b1 && cnt < 20) begin
            reg_we_i  = 1'b0;
            reg_dst_i = 3'($urandom_range(0, 7));
            data_i    = 16'($urandom);
            reg_src_i = {3'd7, reg_dst_i, 3'd1};
            #2;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (src_all[i] !== 48'h0 || busy_all[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_sweep inst%0d: busy=%b src=%h, required busy=1 src=0", i, busy_all[i], src_all[i]);
                end
            end
            step();
            cnt++;
        end
        reg_we_i = 1'b1;
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL reset_busy_edges: got %0d edges, required 8", cnt);
        end
        for (int r = 0; r < 8; r++) begin
            reg_src_i = {3'(r), 3'(r), 3'(r)};
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (src_all[i] !== 48'h0) begin
                    errors++;
                    $display("FAIL reset_zeroed inst%0d R%0d: got %h, required 0", i, r, src_all[i]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        reg_we_i = 1'b0; reg_dst_i = 3'd5; data_i = 16'hBEEF; reg_src_i = '0;
        step();
        reg_we_i = 1'b1;
        reg_src_i = {3'd5, 3'd0, 3'd5};
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (src_all[i][15:0] !== 16'hBEEF || src_all[i][47:32] !== 16'hBEEF) begin
                errors++;
                $display("FAIL write_r5 inst%0d: lane0=%h lane2=%h, required BEEF", i, src_all[i][15:0], src_all[i][47:32]);
            end
        end
        reg_we_i = 1'b0; reg_dst_i = 3'd3; data_i = 16'h1234;
        reg_src_i = {3'd5, 3'd3, 3'd5};
        #2;
        checks++;
        if (src_all[0][31:16] !== 16'h1234 || src_all[2][31:16] !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_r3: got %h/%h, required 1234", src_all[0][31:16], src_all[2][31:16]);
        end
        checks++;
        if (src_all[1][31:16] !== 16'h0000) begin
            errors++;
            $display("FAIL nobypass_r3_before: got %h, required 0000", src_all[1][31:16]);
        end
        step();
        reg_we_i = 1'b1;
        #2;
        checks++;
        if (src_all[1][31:16] !== 16'h1234) begin
            errors++;
            $display("FAIL nobypass_r3_after: got %h, required 1234", src_all[1][31:16]);
        end
    endtask

    task automatic test_zero_reg();
        reg_we_i = 1'b0; reg_dst_i = 3'd0; data_i = 16'hFFFF; reg_src_i = '0;
        #2;
        checks++;
        if (src_all[2] !== 48'h0 || src_all[0] !== {3{16'hFFFF}}) begin
            errors++;
            $display("FAIL zero_reg_write_cycle: zero=%h byp=%h, required 0 and FFFF lanes", src_all[2], src_all[0]);
        end
        step();
        reg_we_i = 1'b1;
        #2;
        checks++;
        if (src_all[2] !== 48'h0 || src_all[0] !== {3{16'hFFFF}} || src_all[1] !== {3{16'hFFFF}}) begin
            errors++;
            $display("FAIL zero_reg_after: zero=%h byp=%h nobyp=%h", src_all[2], src_all[0], src_all[1]);
        end
    endtask

    task automatic test_clear();
        int cnt;
        for (int n = 0; n < 8; n++) begin
            reg_we_i = 1'b0; reg_dst_i = 3'(n); data_i = 16'hA000 | 16'(n << 4);
            step();
        end
        reg_we_i = 1'b1;
        for (int r = 0; r < 8; r++) begin
            reg_src_i = {3'(r), 3'(r), 3'(r)};
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (src_all[i][15:0] !== exp_lane(i, 0)) begin
                    errors++;
                    $display("FAIL fill inst%0d R%0d: got %h, required %h", i, r, src_all[i][15:0], exp_lane(i, 0));
                end
            end
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        cnt = 0;
        while (busy_all[0] === 1'b1 && cnt < 20) begin
            if (cnt == 3) clear_i = 1'b1;
            step();
            clear_i = 1'b0;
            cnt++;
        end
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL clear_busy_edges: got %0d edges, required 8", cnt);
        end
        for (int r = 0; r < 8; r++) begin
            reg_src_i = {3'(r), 3'(r), 3'(r)};
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (src_all[i] !== 48'h0) begin
                    errors++;
                    $display("FAIL clear_zeroed inst%0d R%0d: got %h, required 0", i, r, src_all[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int cnt;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        for (int k = 0; k < 4; k++) step();
        #3;
        rst_i = 1'b1;
        reg_src_i = {3'd1, 3'd2, 3'd3};
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy_all[i] !== 1'b1 || src_all[i] !== 48'h0) begin
                errors++;
                $display("FAIL async_reset inst%0d: busy=%b src=%h, required busy=1 src=0", i, busy_all[i], src_all[i]);
            end
        end
        step();
        step();
        rst_i = 1'b0;
        cnt = 0;
        while (busy_all[0] === 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL async_reset_sweep_edges: got %0d edges, required 8", cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reg_we_i  = ($urandom_range(0, 1) == 0);
            reg_dst_i = 3'($urandom_range(0, 7));
            data_i    = 16'($urandom);
            reg_src_i = ($urandom_range(0, 3) == 0) ? {3{reg_dst_i}} : 9'($urandom);
            clear_i   = ($urandom_range(0, 49) == 0);
            #2;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (busy_all[i] !== exp_busy()) begin
                    errors++;
                    $display("FAIL random_busy cyc%0d inst%0d: got %b, required %b", c, i, busy_all[i], exp_busy());
                end
                for (int p = 0; p < 3; p++) begin
                    checks++;
                    if (src_all[i][p*16 +: 16] !== exp_lane(i, p)) begin
                        errors++;
                        $display("FAIL random_lane cyc%0d inst%0d lane%0d: got %h, required %h",
                                 c, i, p, src_all[i][p*16 +: 16], exp_lane(i, p));
                    end
                end
            end
            step();
        end
        clear_i  = 1'b0;
        reg_we_i = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        zero_model();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_clear();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
